mpu_skew_feeder: RTL and testbench
==================================

// Module: mpu_skew_feeder
// PURPOSE
//  Upstream feeder for the int8 weight-stationary MAC array. It accepts one N-lane
//  activation vector per cycle over a valid/ready handshake. It drives the array's
//  left-edge a_in ports with diagonal skew: lane i is delayed i cycles more than lane 0.
//  It injects zero bubbles when idle or starved, drains N-1 cycles after the last
//  vector, then pulses done.
// PARAMETERS
//  N       4   array rows = lanes per vector (N >= 2)
//  DATA_W  8   activation width; MAC elements take 8
//  CNT_W   16  width of accepted-vector counter
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-low reset
//  in_valid   in   1         upstream vector valid
//  in_ready   out  1         feeder can accept a vector this cycle
//  in_data    in   N*DATA_W  lane i = in_data[i*DATA_W +: DATA_W]
//  in_last    in   1         qualifies the final vector of a tile
//  a_out      out  N*DATA_W  skewed lanes to array row i a_in
//  a_valid    out  N         lane i carries a real (non-bubble) element
//  busy       out  1         high in STREAM or DRAIN
//  done       out  1         1-cycle pulse when the skew pipe is empty after in_last
//  vec_count  out  CNT_W     vectors accepted in current tile
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all delay stages, a_out, a_valid, busy, done,
//    vec_count <= 0; state <= IDLE; in_ready is 0 while rst==0.
//  - Accept = in_valid & in_ready. in_ready = 1 in IDLE and STREAM, 0 in DRAIN.
//  - FSM IDLE -> STREAM on the first accept without in_last.
//  - FSM IDLE/STREAM -> DRAIN on an accept with in_last.
//  - FSM DRAIN: N-1 cycles, counted by drain_cnt.
//    DRAIN -> IDLE after the last drain cycle; done=1 in the cycle the FSM enters IDLE.
//  - Stage-0 input is in_data on accept, else all-zero with valid 0 (bubble).
//    This covers IDLE, STREAM starvation and DRAIN.
//    A zero bubble adds 0 to c_calc, so starvation never corrupts accumulation.
//  - Latency: lane i output = stage-0 input registered (i+1) times.
//    Lane 0 appears 1 cycle after accept; lane N-1 appears N cycles after accept.
//    a_valid[i] travels with lane i data.
//  - Lane data is passed bit-exact with no arithmetic; outputs are registers only.
//  - vec_count: +1 per accept and saturates at 2^CNT_W-1.
//    It clears to 0 in the cycle done pulses.
//  - Accept with in_last while in IDLE: single-vector tile, straight to DRAIN.
//  - A new accept is impossible in DRAIN (in_ready=0).
//    The next tile may be accepted in the done cycle (IDLE, in_ready=1).
//    That accept is pipelined behind the drained tile with no gap.
//  - in_valid=1 while in_ready=0: nothing is consumed; upstream holds data.
//  - rst low mid-STREAM/DRAIN: the pipe is flushed to zero, no done pulse, IDLE.
//    The array also loads weights while rst is low, so both restart aligned.
//  - busy = (state != IDLE).
// STRUCTURE
//  - mpu_pkg holds: MPU_N, MPU_DATA_W localparams, and
//    typedef enum logic [1:0] {FEED_IDLE, FEED_STREAM, FEED_DRAIN} feed_state_t.
//  - Sub-module skew_delay_line #(DEPTH, W) with ports clk, rst, d, d_valid, q,
//    q_valid. It is a DEPTH-stage register chain, sync active-low clear.
//    It is instantiated per lane in a generate loop with DEPTH = i+1.
//  - FSM, drain counter and vec_count live in the top module.
// TESTING
//  - Reset: hold rst=0 3 cycles with in_valid=1 -> in_ready=0, a_out=0,
//    a_valid=0, busy=0, done=0.
//  - N=4, one vector {4,3,2,1}+last -> a_out lane0=1 at t+1, lane1=2 at t+2,
//    lane2=3 at t+3, lane3=4 at t+4; done at t+4; vec_count=1 before clear.
//  - 3 back-to-back vectors (last on 3rd) -> diagonal wavefront;
//    in_ready=0 for 3 DRAIN cycles; done once; no lane overlap.
//  - Starvation: in_valid low 2 cycles mid-tile -> zero lanes with a_valid=0
//    in those slots; 4x4 array result equals golden matmul.
//  - Back-to-back tiles: tile B offered in the done cycle is accepted.
//    B lane0 follows A lane3 wavefront; both tiles' done pulses occur.
//  - Reset mid-DRAIN -> next cycle all outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU activation feeder: default array geometry
// and the feeder FSM state encoding.
package mpu_pkg;

    localparam int MPU_N      = 4;
    localparam int MPU_DATA_W = 8;

    typedef enum logic [1:0] {
        FEED_IDLE,
        FEED_STREAM,
        FEED_DRAIN
    } feed_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage register chain carrying one activation lane and its valid flag.
// Every stage clears synchronously while rst is low so a reset flushes the lane.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    input  logic         d_valid,
    output logic [W-1:0] q,
    output logic         q_valid
);

    logic [W-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;

    // Shift data and valid together one stage per cycle; clear everything on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
                r_vld[k]  <= 1'b0;
            end
        end else begin
            r_data[0] <= d;
            r_vld[0]  <= d_valid;
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k] <= r_data[k-1];
                r_vld[k]  <= r_vld[k-1];
            end
        end
    end

    assign q       = r_data[DEPTH-1];
    assign q_valid = r_vld[DEPTH-1];

endmodule

// File: rtl/mpu_skew_feeder.sv
// Left-edge activation feeder for the weight-stationary MAC array.
// Accepts one N-lane vector per cycle and launches it as a diagonal wavefront:
// lane i is registered i+1 times. Idle or starved cycles inject zero bubbles,
// and after the last vector of a tile the FSM drains N-1 cycles then pulses done.
module mpu_skew_feeder
    import mpu_pkg::*;
#(
    parameter int N      = MPU_N,
    parameter int DATA_W = MPU_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic                in_last,
    output logic [N*DATA_W-1:0] a_out,
    output logic [N-1:0]        a_valid,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    vec_count
);

    localparam int            DCW        = (N > 2) ? $clog2(N) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(N - 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    feed_state_t         r_state;
    logic [DCW-1:0]      r_drain_cnt;
    logic                r_done;
    logic [CNT_W-1:0]    r_vec_count;

    logic                w_accept;
    logic                w_drain_end;
    logic [N*DATA_W-1:0] w_stage0_data;

    // Ready is withheld during reset and while the skew pipe drains.
    assign in_ready      = rst && (r_state != FEED_DRAIN);
    assign w_accept      = in_valid && in_ready;
    assign w_drain_end   = (r_state == FEED_DRAIN) && (r_drain_cnt == DRAIN_LAST);
    // Non-accept cycles feed zeros so bubbles contribute nothing to accumulation.
    assign w_stage0_data = w_accept ? in_data : '0;

    // Tile sequencing: IDLE/STREAM until the last vector, then N-1 drain cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= FEED_IDLE;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
            r_vec_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                FEED_IDLE: begin
                    if (w_accept) begin
                        r_drain_cnt <= '0;
                        r_state     <= in_last ? FEED_DRAIN : FEED_STREAM;
                    end
                end
                FEED_STREAM: begin
                    if (w_accept && in_last) begin
                        r_drain_cnt <= '0;
                        r_state     <= FEED_DRAIN;
                    end
                end
                FEED_DRAIN: begin
                    if (w_drain_end) begin
                        r_state <= FEED_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DCW'(1);
                    end
                end
                default: r_state <= FEED_IDLE;
            endcase

            // Count accepted vectors (saturating); the count resets with done.
            if (w_drain_end) begin
                r_vec_count <= '0;
            end else if (w_accept && (r_vec_count != CNT_MAX)) begin
                r_vec_count <= r_vec_count + CNT_W'(1);
            end
        end
    end

    // One delay line per lane; lane i is i+1 stages deep to form the diagonal skew.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        skew_delay_line #(
            .DEPTH(gi + 1),
            .W    (DATA_W)
        ) u_dly (
            .clk    (clk),
            .rst    (rst),
            .d      (w_stage0_data[gi*DATA_W +: DATA_W]),
            .d_valid(w_accept),
            .q      (a_out[gi*DATA_W +: DATA_W]),
            .q_valid(a_valid[gi])
        );
    end

    assign busy      = (r_state != FEED_IDLE);
    assign done      = r_done;
    assign vec_count = r_vec_count;

endmodule

// File: tb/tb_mpu_skew_feeder.sv
// Scoreboard bench for mpu_skew_feeder: stimulus pushes expected lane elements
// and done pulses (with the clock count they must appear on); a negedge monitor
// pops and compares whenever a lane is valid or done is high.
module tb_mpu_skew_feeder;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [N*DATA_W-1:0] in_data;
    logic                in_last;
    logic [N*DATA_W-1:0] a_out;
    logic [N-1:0]        a_valid;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    vec_count;

    mpu_skew_feeder #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .a_out    (a_out),
        .a_valid  (a_valid),
        .busy     (busy),
        .done     (done),
        .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           lane;
        logic [7:0]   d;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    int   done_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   acc [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, $signed(act), act, $signed(exp), exp, cyc);
        end
    endtask

    function automatic int wgt(input int i, input int j);
        return i * N + j - 5;
    endfunction

    // Monitor: check every valid lane element and done pulse against the scoreboard.
    initial acc = '{default: 0};
    always @(negedge clk) begin
        int idx;
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                if (a_valid[i] === 1'b1) begin
                    idx = -1;
                    for (int k = 0; k < sbq.size(); k++) begin
                        if (sbq[k].lane == i) begin
                            idx = k;
                            break;
                        end
                    end
                    if (idx < 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL lane_unexpected: lane %0d valid with data %0d, nothing expected, cycle %0d",
                                 i, a_out[i*DATA_W +: DATA_W], cyc);
                    end else begin
                        chk($sformatf("lane%0d_data", i), 64'(a_out[i*DATA_W +: DATA_W]), 64'(sbq[idx].d));
                        chk($sformatf("lane%0d_cycle", i), 64'(cyc), 64'(sbq[idx].cyc));
                        sbq.delete(idx);
                    end
                end else begin
                    chk($sformatf("lane%0d_bubble", i), 64'(a_out[i*DATA_W +: DATA_W]), 64'd0);
                end
                for (int j = 0; j < N; j++)
                    acc[j] += int'($signed(a_out[i*DATA_W +: DATA_W])) * wgt(i, j);
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL done_unexpected: done high at cycle %0d, none expected", cyc);
                end else begin
                    chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                end
            end
        end
    end

    // Offer one vector; returns cycles spent waiting for ready and done at the accept.
    task automatic send(input logic [31:0] d, input logic last,
                        output int waits, output logic done_at_acc);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        done_at_acc = done;
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waits);
        end else begin
            for (int i = 0; i < N; i++) begin
                exp_t e;
                e.lane = i;
                e.d    = d[i*DATA_W +: DATA_W];
                e.cyc  = cyc + 1 + i;
                sbq.push_back(e);
            end
            if (last) done_q.push_back(cyc + N);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", k);
        end
    endtask

    logic [31:0] starve_v [4];
    int   golden [N];
    int   snap [N];
    int   w;
    logic dacc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 32'hA5A5_A5A5;

        // Reset held with in_valid high.
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_a_out", 64'(a_out), 64'd0);
            chk("rst_a_valid", 64'(a_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
        end
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single-vector tile {4,3,2,1}.
        send({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, w, dacc);
        chk("single_busy", 64'(busy), 64'd1);
        chk("single_vec_count", 64'(vec_count), 64'd1);
        wait_idle();
        chk("single_done", 64'(done), 64'd1);
        chk("single_vec_clear", 64'(vec_count), 64'd0);
        idle(2);

        // Three back-to-back vectors; ready low for the N-1 drain cycles.
        send(32'h1312_1110, 1'b0, w, dacc);
        send(32'h2322_2120, 1'b0, w, dacc);
        send(32'h3332_3130, 1'b1, w, dacc);
        for (int k = 0; k < N - 1; k++) begin
            @(negedge clk);
            chk("drain_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        chk("drain_end_ready", 64'(in_ready), 64'd1);
        chk("drain_end_done", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        idle(2);

        // Starved tile with signed activations; compare array sums to golden matmul.
        starve_v[0] = {8'h7F, 8'h05, 8'h80, 8'hFF};
        starve_v[1] = {8'h02, 8'hFE, 8'h10, 8'h03};
        starve_v[2] = {8'h81, 8'h01, 8'h00, 8'h40};
        starve_v[3] = {8'h09, 8'hF7, 8'h22, 8'hC0};
        golden = '{default: 0};
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    golden[j] += int'($signed(starve_v[k][i*8 +: 8])) * wgt(i, j);
        snap = acc;
        send(starve_v[0], 1'b0, w, dacc);
        send(starve_v[1], 1'b0, w, dacc);
        in_valid = 1'b0;
        @(negedge clk);
        chk("starve_ready", 64'(in_ready), 64'd1);
        chk("starve_busy", 64'(busy), 64'd1);
        idle(2);
        send(starve_v[2], 1'b0, w, dacc);
        send(starve_v[3], 1'b1, w, dacc);
        wait_idle();
        idle(2);
        for (int j = 0; j < N; j++)
            chk($sformatf("matmul_col%0d", j), 64'(acc[j] - snap[j]), 64'(golden[j]));

        // Back-to-back tiles: B offered during A's drain, accepted in A's done cycle.
        send(32'h4443_4241, 1'b0, w, dacc);
        send(32'h5453_5251, 1'b1, w, dacc);
        send(32'h6463_6261, 1'b1, w, dacc);
        chk("b2b_wait_cycles", 64'(w), 64'(N - 1));
        chk("b2b_done_at_accept", 64'(dacc), 64'd1);
        chk("b2b_vec_count", 64'(vec_count), 64'd1);
        wait_idle();
        idle(2);

        // Nine vectors in one tile: vec_count saturates at 7.
        for (int k = 0; k < 9; k++)
            send(32'h0101_0101 * (k + 1), (k == 8), w, dacc);
        chk("vec_count_sat", 64'(vec_count), 64'd7);
        wait_idle();
        chk("sat_vec_clear", 64'(vec_count), 64'd0);
        idle(2);

        // Reset during drain: pipe flushed, no done pulse.
        send(32'h7473_7271, 1'b1, w, dacc);
        @(negedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        done_q.delete();
        @(negedge clk);
        chk("mid_rst_a_out", 64'(a_out), 64'd0);
        chk("mid_rst_a_valid", 64'(a_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_vec_count", 64'(vec_count), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(4);
        chk("after_rst_busy", 64'(busy), 64'd0);
        chk("after_rst_in_ready", 64'(in_ready), 64'd1);

        // Everything expected must have been seen.
        chk("sb_lane_left", 64'(sbq.size()), 64'd0);
        chk("sb_done_left", 64'(done_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
